// File: rtl/riscv_ctrl_seq.sv
// RV32I single-cycle control sequencer: decode, branch resolve, memory wait, trap.
// Optional PERF_CNT_EN adds retired/stallCycles performance counters.
module riscv_ctrl_seq #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instrValid,
    input  logic        zero,
    input  logic        negative,
    input  logic        overflow,
    input  logic        carry,
    input  logic        memAck,
    output logic        regWrite,
    output logic        PCsrc,
    output logic        Jsrc,
    output logic        ALUsrcB,
    output logic [1:0]  ALUsrcA,
    output logic [3:0]  ALUcontrol,
    output logic [1:0]  immSrc,
    output logic [1:0]  resultSrc,
    output logic        pcEn,
    output logic        memReq,
    output logic        memWe,
    output logic        trap,
`ifdef PERF_CNT_EN
    output logic [31:0] retired,
    output logic [31:0] stallCycles,
`endif
    output logic [1:0]  trapCause
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO = CW'(TIMEOUT);

    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0] cause, cause_n;

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic illegal, isMem, isStore, decRw, taken, timedOut;
    logic unused_bits;

    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    function automatic logic [3:0] alu_fn(input logic [2:0] f, input logic alt);
        case (f)
            3'b000:  alu_fn = alt ? 4'b0001 : 4'b0000;
            3'b001:  alu_fn = 4'b0111;
            3'b010:  alu_fn = 4'b0101;
            3'b011:  alu_fn = 4'b0110;
            3'b100:  alu_fn = 4'b0100;
            3'b101:  alu_fn = alt ? 4'b1001 : 4'b1000;
            3'b110:  alu_fn = 4'b0011;
            default: alu_fn = 4'b0010;
        endcase
    endfunction

    always_comb begin
        case (f3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = negative ^ overflow;
            3'b101:  taken = !(negative ^ overflow);
            3'b110:  taken = !carry;
            default: taken = carry;
        endcase
    end

    always_comb begin
        illegal    = 1'b0;
        isMem      = 1'b0;
        isStore    = 1'b0;
        decRw      = 1'b0;
        PCsrc      = 1'b0;
        Jsrc       = 1'b0;
        ALUsrcB    = 1'b0;
        ALUsrcA    = 2'b00;
        ALUcontrol = 4'b0000;
        immSrc     = 2'b00;
        resultSrc  = 2'b00;
        unique case (1'b1)
            op == 7'b0110011: begin
                decRw      = 1'b1;
                ALUcontrol = alu_fn(f3, f7[5]);
                illegal    = !(f7 == 7'b0000000 ||
                               (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            op == 7'b0010011: begin
                decRw      = 1'b1;
                ALUsrcB    = 1'b1;
                ALUcontrol = alu_fn(f3, f3 == 3'b101 && f7[5]);
                if (f3 == 3'b001)
                    illegal = f7 != 7'b0000000;
                else if (f3 == 3'b101)
                    illegal = !(f7 == 7'b0000000 || f7 == 7'b0100000);
            end
            op == 7'b0000011: begin
                isMem     = 1'b1;
                decRw     = 1'b1;
                ALUsrcB   = 1'b1;
                resultSrc = 2'b10;
                illegal   = f3 != 3'b010;
            end
            op == 7'b0100011: begin
                isMem   = 1'b1;
                isStore = 1'b1;
                ALUsrcB = 1'b1;
                immSrc  = 2'b01;
                illegal = f3 != 3'b010;
            end
            op == 7'b1100011: begin
                ALUcontrol = 4'b0001;
                immSrc     = 2'b10;
                PCsrc      = taken;
                illegal    = f3[2:1] == 2'b01;
            end
            op == 7'b1101111: begin
                decRw     = 1'b1;
                PCsrc     = 1'b1;
                ALUsrcA   = 2'b01;
                ALUsrcB   = 1'b1;
                immSrc    = 2'b11;
                resultSrc = 2'b01;
            end
            op == 7'b1100111: begin
                decRw     = 1'b1;
                PCsrc     = 1'b1;
                Jsrc      = 1'b1;
                ALUsrcB   = 1'b1;
                resultSrc = 2'b01;
                illegal   = f3 != 3'b000;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign timedOut = (TIMEOUT != 0) && (cnt == TO);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        cause_n  = cause;
        pcEn     = 1'b0;
        regWrite = 1'b0;
        memReq   = 1'b0;
        case (state)
            RUN: begin
                if (instrValid) begin
                    if (illegal) begin
                        state_n = TRAP;
                        cause_n = 2'b01;
                    end else if (isMem) begin
                        memReq = 1'b1;
                        if (memAck) begin
                            pcEn     = 1'b1;
                            regWrite = !isStore;
                        end else begin
                            state_n = MEM_WAIT;
                            cnt_n   = CW'(1);
                        end
                    end else begin
                        pcEn     = 1'b1;
                        regWrite = decRw;
                    end
                end
            end
            MEM_WAIT: begin
                memReq = 1'b1;
                // a late ack still beats the timeout on the same cycle
                if (memAck) begin
                    pcEn     = 1'b1;
                    regWrite = !isStore;
                    state_n  = RUN;
                end else if (timedOut) begin
                    state_n = TRAP;
                    cause_n = 2'b10;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: ;
        endcase
        if (rst) begin
            pcEn     = 1'b0;
            regWrite = 1'b0;
            memReq   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
            cause <= 2'b00;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            cause <= cause_n;
        end
    end

    assign memWe     = memReq & isStore;
    assign trap      = state == TRAP;
    assign trapCause = cause;

`ifdef PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retired     <= '0;
            stallCycles <= '0;
        end else begin
            if (pcEn)
                retired <= retired + 32'd1;
            if (state == MEM_WAIT || (state == RUN && !instrValid))
                stallCycles <= stallCycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_ctrl_seq.sv
// Directed scoreboard bench for riscv_ctrl_seq.
module tb_riscv_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst, instrValid, zero, negative, overflow, carry, memAck;
    logic [31:0] instr;
    logic        regWrite, PCsrc, Jsrc, ALUsrcB, pcEn, memReq, memWe, trap;
    logic [1:0]  ALUsrcA, immSrc, resultSrc, trapCause;
    logic [3:0]  ALUcontrol;
`ifdef PERF_CNT_EN
    logic [31:0] retired, stallCycles;
`endif

    riscv_ctrl_seq #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instrValid(instrValid),
        .zero(zero), .negative(negative), .overflow(overflow), .carry(carry),
        .memAck(memAck), .regWrite(regWrite), .PCsrc(PCsrc), .Jsrc(Jsrc),
        .ALUsrcB(ALUsrcB), .ALUsrcA(ALUsrcA), .ALUcontrol(ALUcontrol),
        .immSrc(immSrc), .resultSrc(resultSrc), .pcEn(pcEn), .memReq(memReq),
        .memWe(memWe), .trap(trap),
`ifdef PERF_CNT_EN
        .retired(retired), .stallCycles(stallCycles),
`endif
        .trapCause(trapCause)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] SUB  = 32'h402081B3;
    localparam logic [31:0] MUL  = 32'h022081B3;
    localparam logic [31:0] LW   = 32'h0000A283;
    localparam logic [31:0] SW   = 32'h0020A223;
    localparam logic [31:0] BLT  = 32'h0020C463;
    localparam logic [31:0] BGEU = 32'h0020F463;
    localparam logic [31:0] JALR = 32'h000100E7;
    localparam logic [31:0] JAL  = 32'h0000006F;
    localparam logic [31:0] LUI  = 32'h00000037;

    typedef struct {
        string       tag;
        logic [6:0]  ctl;
        logic [12:0] dm;
        logic [12:0] dv;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    // ctl = {regWrite,pcEn,memReq,memWe,trap,trapCause}
    // dec = {PCsrc,Jsrc,ALUsrcB,ALUsrcA,ALUcontrol,immSrc,resultSrc}
    task automatic step(input string tag, input logic r, input logic [31:0] ins,
                        input logic v, input logic [3:0] f, input logic ack,
                        input logic [6:0] ectl, input logic [12:0] dm,
                        input logic [12:0] dv);
        exp_t e;
        logic [19:0] obs, want;
        @(posedge clk);
        #1;
        rst = r;
        instr = ins;
        instrValid = v;
        {zero, negative, overflow, carry} = f;
        memAck = ack;
        sb.push_back('{tag, ectl, dm, dv});
        @(negedge clk);
        e = sb.pop_front();
        obs = {regWrite, pcEn, memReq, memWe, trap, trapCause,
               {PCsrc, Jsrc, ALUsrcB, ALUsrcA, ALUcontrol, immSrc, resultSrc} & e.dm};
        want = {e.ctl, e.dv & e.dm};
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, want);
        end
    endtask

    initial begin
        rst = 1'b1;
        instr = ADD;
        instrValid = 1'b0;
        {zero, negative, overflow, carry} = 4'b0;
        memAck = 1'b0;
        repeat (2) @(posedge clk);

        step("reset",   1, ADD, 1, 4'b0000, 0, 7'b0000000, 13'h0000, 13'h0000);
        step("idle",    0, ADD, 0, 4'b0000, 1, 7'b0000000, 13'h0000, 13'h0000);
        step("add",     0, ADD, 1, 4'b0000, 0, 7'b1100000, 13'h17F3, 13'h0000);
        step("sub",     0, SUB, 1, 4'b0000, 1, 7'b1100000, 13'h00F0, 13'h0010);
        step("lw_w0",   0, LW,  1, 4'b0000, 0, 7'b0010000, 13'h0000, 13'h0000);
        step("lw_w1",   0, LW,  1, 4'b0000, 0, 7'b0010000, 13'h0000, 13'h0000);
        step("lw_w2",   0, LW,  1, 4'b0000, 0, 7'b0010000, 13'h0000, 13'h0000);
        step("lw_done", 0, LW,  1, 4'b0000, 1, 7'b1110000, 13'h0003, 13'h0002);
        step("sw",      0, SW,  1, 4'b0000, 1, 7'b0111000, 13'h000C, 13'h0004);
        step("blt_t",   0, BLT, 1, 4'b0100, 0, 7'b0100000, 13'h10F0, 13'h1010);
        step("blt_nt",  0, BLT, 1, 4'b0110, 0, 7'b0100000, 13'h10F0, 13'h0010);
        step("bgeu_t",  0, BGEU, 1, 4'b0001, 0, 7'b0100000, 13'h1000, 13'h1000);
        step("bgeu_nt", 0, BGEU, 1, 4'b0000, 0, 7'b0100000, 13'h1000, 13'h0000);
        step("jalr",    0, JALR, 1, 4'b0000, 0, 7'b1100000, 13'h1803, 13'h1801);
        step("jal",     0, JAL, 1, 4'b0000, 0, 7'b1100000, 13'h1803, 13'h1001);
        step("bad_idle", 0, LUI, 0, 4'b0000, 0, 7'b0000000, 13'h0000, 13'h0000);

        step("ackwin_run", 0, LW, 1, 4'b0000, 0, 7'b0010000, 13'h0000, 13'h0000);
        for (int i = 1; i < 16; i++)
            step("ackwin_wait", 0, LW, 1, 4'b0000, 0, 7'b0010000, 13'h0000, 13'h0000);
        step("ackwin_done", 0, LW, 1, 4'b0000, 1, 7'b1110000, 13'h0000, 13'h0000);
        step("ackwin_next", 0, ADD, 1, 4'b0000, 0, 7'b1100000, 13'h0000, 13'h0000);

        step("rstmid_run",  0, SW, 1, 4'b0000, 0, 7'b0011000, 13'h0000, 13'h0000);
        step("rstmid_wait", 0, SW, 1, 4'b0000, 0, 7'b0011000, 13'h0000, 13'h0000);
        step("rstmid_rst",  1, SW, 1, 4'b0000, 0, 7'b0000000, 13'h0000, 13'h0000);
        step("rstmid_add",  0, ADD, 1, 4'b0000, 0, 7'b1100000, 13'h0000, 13'h0000);

        step("to_run", 0, LW, 1, 4'b0000, 0, 7'b0010000, 13'h0000, 13'h0000);
        for (int i = 1; i <= 16; i++)
            step("to_wait", 0, LW, 1, 4'b0000, 0, 7'b0010000, 13'h0000, 13'h0000);
        step("to_trap0", 0, LW,  1, 4'b0000, 1, 7'b0000110, 13'h0000, 13'h0000);
        step("to_trap1", 0, ADD, 1, 4'b0000, 1, 7'b0000110, 13'h0003, 13'h0000);
        step("to_rst",   1, ADD, 1, 4'b0000, 0, 7'b0000110, 13'h0000, 13'h0000);
        step("to_clear", 0, ADD, 0, 4'b0000, 0, 7'b0000000, 13'h0000, 13'h0000);

        step("lui_run",  0, LUI, 1, 4'b0000, 0, 7'b0000000, 13'h0000, 13'h0000);
        step("lui_trap", 0, ADD, 1, 4'b0000, 0, 7'b0000101, 13'h0000, 13'h0000);
        step("lui_rst",  1, ADD, 0, 4'b0000, 0, 7'b0000101, 13'h0000, 13'h0000);
        step("lui_clr",  0, ADD, 0, 4'b0000, 0, 7'b0000000, 13'h0000, 13'h0000);
`ifdef PERF_CNT_EN
        total++;
        assert (retired === 32'd0) else begin
            bad++;
            $error("FAIL retired_rst observed=%h expected=%h", retired, 32'd0);
        end
`endif
        step("mul_run",  0, MUL, 1, 4'b0000, 0, 7'b0000000, 13'h0000, 13'h0000);
        step("mul_trap", 0, ADD, 1, 4'b0000, 0, 7'b0000101, 13'h0000, 13'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_ctrl_seq.md
Name: riscv_ctrl_seq

Overview:
Control unit that sequences the RV32I single-cycle datapath. It decodes the current instruction into datapath controls and resolves branches from the ALU flags. It also stretches load/store instructions across data-memory wait states through a req/ack handshake. PC advance and register writes are gated so that architectural state commits only when an instruction completes. Illegal instructions and bus timeouts are caught in a sticky trap state.

Parameters:
TIMEOUT, 16, maximum cycles memReq may stay high without memAck before a bus-timeout trap; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
instr  in  32  current instruction
instrValid  in  1  instr is valid this cycle
zero, negative, overflow, carry  in  1 each  ALU flags (carry=1 means no borrow on subtract)
memAck  in  1  data memory completes the access this cycle
regWrite  out  1  register file write enable (gated)
PCsrc  out  1  1 selects branch/jump target
Jsrc  out  1  1 selects rs1 as target base (JALR)
ALUsrcB  out  1  1 selects immediate
ALUsrcA  out  2  00 rs1, 01 PC, 10 zero
ALUcontrol  out  4  ALU operation
immSrc  out  2  00 I, 01 S, 10 B, 11 J
resultSrc  out  2  00 ALU, 01 PC+4, 10 readData
pcEn  out  1  PC register enable; PC holds when 0
memReq  out  1  data memory request
memWe  out  1  store (1) or load (0), valid with memReq
trap  out  1  sticky trap indication
trapCause  out  2  00 none, 01 illegal instruction, 10 bus timeout

Behaviour:
- Reset: state=RUN, trap=0, trapCause=00, timeout counter=0. In the first cycle after reset, the combinational outputs follow instr.
- ALUcontrol encoding: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
- Supported opcodes: OP, OP-IMM, LOAD (LW), STORE (SW), BRANCH, JAL, JALR.
- Illegal instructions: any other opcode, other load/store widths, and funct7 mismatches. LUI and AUIPC are illegal in this revision.
- Branches:
  - ALU performs sub.
  - Taken conditions: beq zero; bne !zero; blt negative^overflow; bge !(negative^overflow); bltu !carry; bgeu carry.
  - PCsrc=taken.
- JAL: PCsrc=1, Jsrc=0, resultSrc=01, regWrite=1.
- JALR: PCsrc=1, Jsrc=1, immSrc=00, resultSrc=01, regWrite=1.
- State RUN:
  - instrValid=0: pcEn=0, regWrite=0, memReq=0.
  - Non-memory valid instruction: completes in one cycle, pcEn=1, regWrite per decode.
  - Load/store: memReq=1 (memWe=1 for SW).
    - If memAck=1 in the same cycle: completes (zero wait), pcEn=1, regWrite=1 for LW only.
    - If memAck=0: pcEn=0, regWrite=0, go to MEM_WAIT, counter cleared to 1.
  - Illegal instruction: go to TRAP, trapCause=01, pcEn=0, regWrite=0.
- State MEM_WAIT:
  - memReq held at 1; instr is held stable upstream because pcEn=0.
  - memAck=1: pcEn=1, regWrite=1 for LW only, return to RUN.
  - Otherwise: counter increments.
  - Counter reaches TIMEOUT with no ack (TIMEOUT>0): go to TRAP, trapCause=10, memReq drops next cycle.
  - memAck asserted in the same cycle the counter reaches TIMEOUT: ack wins and the instruction completes.
- State TRAP:
  - pcEn=0, regWrite=0, memReq=0, trap=1.
  - Exit only by rst.
  - Decode outputs (ALU selects etc.) still follow instr but are inert.
- Ordering and gating:
  - memAck outside an active memReq is ignored.
  - rst mid-access: returns to RUN immediately; memReq=0 in the reset cycle.
  - regWrite is never asserted when pcEn=0; the two assert together only on completion.

Optional Feature:
PERF_CNT_EN
- Defined: adds outputs retired[31:0] and stallCycles[31:0].
  - retired increments on every cycle with pcEn=1.
  - stallCycles increments on every MEM_WAIT cycle and every RUN cycle with instrValid=0.
  - Both counters clear on rst, wrap 0xFFFFFFFF->0, and freeze in TRAP.
- Undefined: these ports and counters do not exist.

Test Plan:
1. add x3,x1,x2 (0x002081B3), instrValid=1 -> ALUcontrol=0000, ALUsrcA=00, ALUsrcB=0, resultSrc=00, regWrite=1, pcEn=1, memReq=0.
2. lw x5,0(x1) with memAck low 3 cycles then high -> memReq=1 for 4 cycles, memWe=0; pcEn=0 and regWrite=0 for 3 cycles, then both =1 with resultSrc=10 in cycle 4; back in RUN.
3. sw with memAck=1 in the first cycle -> memReq=1, memWe=1, pcEn=1, regWrite=0, immSrc=01, single cycle.
4. blt with negative=1, overflow=0 -> PCsrc=1; blt with negative=1, overflow=1 -> PCsrc=0; bgeu with carry=1 -> PCsrc=1; jalr -> Jsrc=1, resultSrc=01.
5. TIMEOUT=16, lw with memAck never asserted -> trap=1, trapCause=10 after the 16th wait cycle; pcEn=0 and memReq=0 thereafter until rst.
6. instr=0x00000037 (LUI) -> trap=1, trapCause=01, regWrite=0; rst=1 for one cycle -> trap=0, state RUN; with PERF_CNT_EN, retired=0 after rst.
